// File: rtl/minimac2_rx_mii.sv
// minimac2 MII receive engine: strips preamble/SFD, assembles nibbles into buffer bytes, reports frames.
// Define MINIMAC2_RX_CRC_EN to build the FCS checker; otherwise rx_crc_ok is tied high.
module minimac2_rx_mii #(
    parameter logic [10:0] MAX_BYTES = 11'd1530
) (
    input  logic        phy_rx_clk,
    input  logic        phy_rx_rst,
    input  logic        phy_dv,
    input  logic        phy_rx_er,
    input  logic [3:0]  phy_rx_data,
    input  logic        rx_ready,
    output logic [10:0] rxb_adr,
    output logic [7:0]  rxb_dat,
    output logic        rxb_we,
    output logic        rx_done,
    output logic [10:0] rx_count,
    output logic        rx_drop,
    output logic        rx_crc_ok
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        RECV_LO,
        RECV_HI,
        DISCARD,
        FINISH
    } state_t;

    state_t      state, state_next;
    logic        dv_r, er_r;
    logic [3:0]  d_r;
    logic        armed;
    logic [10:0] byte_count;
    logic [3:0]  lo;
    logic        wr_pend;
    logic [7:0]  wr_byte;
    logic        latch_lo, set_pend, drop_now, done_now;

    // Input stage is never reset so dv_r keeps tracking the line through a reset.
    always_ff @(posedge phy_rx_clk) begin
        dv_r <= phy_dv;
        er_r <= phy_rx_er;
        d_r  <= phy_rx_data;
    end

    always_comb begin
        state_next = state;
        latch_lo   = 1'b0;
        set_pend   = 1'b0;
        drop_now   = 1'b0;
        done_now   = 1'b0;
        case (state)
            IDLE: begin
                if (armed && dv_r && d_r == 4'h5) state_next = PREAMBLE;
            end
            PREAMBLE: begin
                if (!dv_r) begin
                    state_next = IDLE;
                end else if (d_r == 4'hD) begin
                    if (rx_ready) begin
                        state_next = RECV_LO;
                    end else begin
                        state_next = DISCARD;
                        drop_now   = 1'b1;
                    end
                end else if (d_r != 4'h5) begin
                    state_next = DISCARD;
                end
            end
            RECV_LO: begin
                if (!dv_r) begin
                    state_next = FINISH;
                end else if (er_r) begin
                    state_next = DISCARD;
                    drop_now   = 1'b1;
                end else begin
                    latch_lo   = 1'b1;
                    state_next = RECV_HI;
                end
            end
            RECV_HI: begin
                if (!dv_r) begin
                    state_next = FINISH;
                end else if (er_r || byte_count == MAX_BYTES) begin
                    state_next = DISCARD;
                    drop_now   = 1'b1;
                end else begin
                    set_pend   = 1'b1;
                    state_next = RECV_LO;
                end
            end
            DISCARD: begin
                if (!dv_r) state_next = IDLE;
            end
            FINISH: begin
                state_next = IDLE;
                if (byte_count == '0) drop_now = 1'b1;
                else                  done_now = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // A completed byte is staged in wr_byte for one cycle before it is written out.
    always_ff @(posedge phy_rx_clk) begin
        if (phy_rx_rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            byte_count <= '0;
            lo         <= '0;
            wr_pend    <= 1'b0;
            wr_byte    <= '0;
            rxb_we     <= 1'b0;
            rxb_adr    <= '0;
            rxb_dat    <= '0;
            rx_done    <= 1'b0;
            rx_drop    <= 1'b0;
            rx_count   <= '0;
        end else begin
            state   <= state_next;
            if (!dv_r) armed <= 1'b1;
            if (latch_lo) lo <= d_r;
            wr_pend <= set_pend;
            if (set_pend) wr_byte <= {d_r, lo};
            rxb_we  <= wr_pend;
            if (wr_pend) begin
                rxb_adr    <= byte_count;
                rxb_dat    <= wr_byte;
                byte_count <= byte_count + 11'd1;
            end
            if (state == IDLE) byte_count <= '0;
            rx_done <= done_now;
            rx_drop <= drop_now;
            if (done_now) rx_count <= byte_count;
        end
    end

`ifdef MINIMAC2_RX_CRC_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'd0, b};
        for (int unsigned i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // The register runs LSB-first, so it is bit-reversed before comparing with the MSB-first residue.
    always_ff @(posedge phy_rx_clk) begin
        if (phy_rx_rst) begin
            crc       <= '1;
            rx_crc_ok <= 1'b0;
        end else begin
            if (state == IDLE) crc <= '1;
            else if (wr_pend)  crc <= crc_next(crc, wr_byte);
            if (done_now) rx_crc_ok <= (bit_rev(crc) == 32'hC704DD7B);
        end
    end
`else
    assign rx_crc_ok = 1'b1;
`endif

endmodule

// File: doc/minimac2_rx_mii.md
Name: minimac2_rx_mii

Overview:
- MII receive engine for the minimac2 Ethernet MAC, in the phy_rx_clk domain.
- Strips preamble and SFD, then assembles nibbles (low nibble first) into bytes.
- Writes each byte into a host-supplied receive buffer and reports completed frames with a length.
- Counterpart of the MII transmit engine; the host side owns buffer arbitration and clock-domain crossing.

Parameters:
- MAX_BYTES, 11'd1530: the largest frame accepted (bytes after the SFD, FCS included). Larger frames are discarded.

Ports:
- phy_rx_clk  in  1  MII receive clock; the only clock.
- phy_rx_rst  in  1  synchronous, active-high reset.
- phy_dv  in  1  MII RX_DV.
- phy_rx_er  in  1  MII RX_ER.
- phy_rx_data  in  4  MII RXD.
- rx_ready  in  1  host level: a buffer slot is free. Sampled only at the SFD.
- rxb_adr  out  11  buffer write address (byte index in the frame).
- rxb_dat  out  8  buffer write data.
- rxb_we  out  1  buffer write strobe, one cycle per byte.
- rx_done  out  1  one-cycle pulse: a good frame is complete.
- rx_count  out  11  byte count, valid while rx_done=1.
- rx_drop  out  1  one-cycle pulse: a frame was discarded.
- rx_crc_ok  out  1  FCS check result, valid while rx_done=1.

Behaviour:
- Input stage: phy_dv, phy_rx_er and phy_rx_data pass through one register stage (dv_r, er_r, d_r). All decisions below use the registered values.
- Reset: state=IDLE, byte_count=0. rxb_we, rx_done and rx_drop are 0. rxb_adr, rxb_dat and rx_count are 0. rx_crc_ok is 0.
- Reset mid-frame returns to IDLE with no pulses. The remainder of that frame is ignored until dv_r has been 0 for at least one cycle.

States: IDLE, PREAMBLE, RECV_LO, RECV_HI, DISCARD, FINISH.
- IDLE: byte_count cleared. When dv_r=1 and d_r=4'h5, go to PREAMBLE.
- PREAMBLE:
  - d_r=4'h5: stay.
  - d_r=4'hD: SFD. If rx_ready=1, go to RECV_LO; otherwise go to DISCARD.
  - Any other value, or dv_r=0: go to DISCARD (or IDLE if dv_r=0). No rx_drop pulse is issued for a bad preamble.
- RECV_LO:
  - dv_r=1: latch d_r as the low nibble, go to RECV_HI.
  - dv_r=0: go to FINISH.
- RECV_HI:
  - dv_r=1: write byte {d_r, lo}. rxb_we=1 on the next cycle, with rxb_adr=byte_count at that time; byte_count then increments. Go to RECV_LO.
  - dv_r=0: trailing dribble nibble. Discard it, go to FINISH.
- Byte write timing: rxb_we, rxb_adr and rxb_dat are registered and valid together for exactly one cycle.
- Error (er_r=1 while dv_r=1 in RECV_LO or RECV_HI): go to DISCARD.
- Overflow: a high nibble arriving when byte_count==MAX_BYTES is not written; go to DISCARD.
- DISCARD:
  - Pulse rx_drop once when the frame had passed the SFD: rx_ready low at the SFD, an error, or overflow.
  - Stay until dv_r=0, then go to IDLE.
  - Bytes already written are abandoned; the host ignores them.
- FINISH (one cycle), then IDLE:
  - byte_count==0: pulse rx_drop.
  - Otherwise: rx_done=1 with rx_count=byte_count, and rx_crc_ok valid in the same cycle.
- Latency:
  - First rxb_we occurs 3 cycles after the first data high nibble appears on phy_rx_data.
  - rx_done occurs 3 cycles after the first phy_dv=0 sample.
- Pulse exclusivity: rx_done and rx_drop are never high together. At most one of them fires per frame.
- Back-to-back frames: the minimum IPG of one dv=0 cycle is supported. IDLE can detect a preamble on the cycle after FINISH.

Optional Feature:
- MINIMAC2_RX_CRC_EN defined:
  - A CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) is updated per written byte and reset in IDLE.
  - rx_crc_ok=1 in FINISH exactly when the residue equals 32'hC704DD7B.
- MINIMAC2_RX_CRC_EN undefined: no CRC logic; rx_crc_ok is constant 1.

Test Plan:
- 7x4'h5, 4'hD, then 64 bytes 0x00..0x3F with a valid FCS (68 bytes), rx_ready=1:
  - 68 rxb_we pulses, addresses 0..67, data as sent.
  - rx_done once with rx_count=68 and rx_crc_ok=1 (CRC_EN); no rx_drop.
- Same frame with one payload bit flipped: rx_done, rx_count=68, rx_crc_ok=0 with CRC_EN; 1 without.
- rx_ready=0 at the SFD: zero rxb_we, one rx_drop, no rx_done. A following good frame (IPG 1 cycle, rx_ready=1) is received normally.
- phy_rx_er=1 during byte 10: rxb_we for bytes 0..9 only, then one rx_drop, no rx_done.
- MAX_BYTES=16, 20-byte frame: 16 writes (addresses 0..15), one rx_drop, no rx_done.
- 5-byte frame plus one extra low nibble before dv drops: rx_done with rx_count=5. Also: SFD immediately followed by dv=0 gives one rx_drop. Also: phy_rx_rst asserted mid-frame gives no pulses, and the next frame is received normally.
